// File: rtl/turbo_iter_ctrl.sv
// -----------------------------------------------------------------------------
// turbo_iter_ctrl
//
// Iteration scheduler for the turbo decoder datapath. A 216-bit frame is
// captured once and held on the SISO field outputs. The controller then runs
// alternating half-iterations: decoder 1 in natural order, then decoder 2 in
// interleaved order. It repeats up to MAX_ITER full iterations and returns the
// decoder-2 hard decision of the last iteration through a valid/ready handshake.
//
// Optional build macro:
//   TURBO_EARLY_STOP_EN - when defined, the frame finishes early once two
//                         consecutive full iterations give identical hard
//                         decisions. When undefined, every frame runs
//                         exactly MAX_ITER iterations.
//
// Parameters:
//   MAX_ITER  maximum full iterations per frame (1..31)
//   ITER_W    width of the iteration counter (must hold MAX_ITER)
//
// Ports:
//   clk_p_i        clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   frm_valid_i    input frame valid
//   frm_ready_o    controller can accept a frame (IDLE only)
//   data_i         frame: [215:144] enc, [143:72] sys, [71:0] ext
//   siso_start_o   one-cycle pulse launching a half-iteration
//   siso_sel_o     0 = decoder 1 (natural), 1 = decoder 2 (interleaved)
//   siso_enc_o     captured enc field, held for the whole frame
//   siso_sys_o     captured sys field, held for the whole frame
//   siso_ext_o     captured ext field, held for the whole frame
//   siso_done_i    SISO half-iteration complete (single-cycle pulse)
//   siso_hard_i    SISO hard decisions, valid with siso_done_i
//   out_valid_o    decoded word available
//   out_ready_i    downstream accepts the decoded word
//   data_o         decoded hard-decision word
//   iter_cnt_o     completed full iterations for the current or last frame
//   busy_o         high in every state except IDLE
// -----------------------------------------------------------------------------
module turbo_iter_ctrl #(
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = 5
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              frm_valid_i,
  output logic              frm_ready_o,
  input  logic [215:0]      data_i,
  output logic              siso_start_o,
  output logic              siso_sel_o,
  output logic [71:0]       siso_enc_o,
  output logic [71:0]       siso_sys_o,
  output logic [71:0]       siso_ext_o,
  input  logic              siso_done_i,
  input  logic [15:0]       siso_hard_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [15:0]       data_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_RUN2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_CHECK = 3'd5,
    S_OUT   = 3'd6
  } state_e;

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_e              state_q, state_d;
  logic [71:0]         enc_q, sys_q, ext_q;
  logic [15:0]         data_q;
  logic [ITER_W-1:0]   iter_q;
  logic                frm_ready_q;
  logic                start_q;
  logic                sel_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                frm_accept;
  logic                stop_now;
  logic                early_hit;

  // Saturating increment: the counter sticks at MAX_ITER and never wraps.
  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    if (v >= ITER_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // frm_ready_q is high exactly when the state is IDLE, so it doubles as the
  // accept qualifier.
  assign frm_accept = frm_ready_q & frm_valid_i;

`ifdef TURBO_EARLY_STOP_EN
  logic [15:0] prev_hard_q;
  logic        prev_vld_q;

  // Converged: decisions unchanged across two consecutive full iterations.
  // prev_vld_q is clear during the first CHECK, so iteration 1 never stops.
  assign early_hit = prev_vld_q & (data_q == prev_hard_q);

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_hard_q <= '0;
      prev_vld_q  <= 1'b0;
    end else if (state_q == S_IDLE && frm_accept) begin
      prev_vld_q  <= 1'b0;
    end else if (state_q == S_CHECK && !stop_now) begin
      prev_hard_q <= data_q;
      prev_vld_q  <= 1'b1;
    end
  end
`else
  assign early_hit = 1'b0;
`endif

  assign stop_now = (iter_q == ITER_MAX) | early_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frm_accept)  state_d = S_RUN1;
      S_RUN1:                   state_d = S_WAIT1;
      S_WAIT1: if (siso_done_i) state_d = S_RUN2;
      S_RUN2:                   state_d = S_WAIT2;
      S_WAIT2: if (siso_done_i) state_d = S_CHECK;
      S_CHECK: state_d = stop_now ? S_OUT : S_RUN1;
      S_OUT:   if (out_ready_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and registered outputs. Outputs are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      enc_q       <= '0;
      sys_q       <= '0;
      ext_q       <= '0;
      data_q      <= '0;
      iter_q      <= '0;
      frm_ready_q <= 1'b1;
      start_q     <= 1'b0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frm_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      start_q     <= (state_d == S_RUN1) || (state_d == S_RUN2);
      sel_q       <= (state_d == S_RUN2) || (state_d == S_WAIT2);
      out_valid_q <= (state_d == S_OUT);

      if (state_q == S_IDLE && frm_accept) begin
        enc_q  <= data_i[215:144];
        sys_q  <= data_i[143:72];
        ext_q  <= data_i[71:0];
        iter_q <= '0;
      end

      // Only decoder-2 decisions are kept; decoder-1 hard output is dropped.
      if (state_q == S_WAIT2 && siso_done_i) begin
        data_q <= siso_hard_i;
        iter_q <= sat_inc(iter_q);
      end
    end
  end

  assign frm_ready_o  = frm_ready_q;
  assign siso_start_o = start_q;
  assign siso_sel_o   = sel_q;
  assign siso_enc_o   = enc_q;
  assign siso_sys_o   = sys_q;
  assign siso_ext_o   = ext_q;
  assign out_valid_o  = out_valid_q;
  assign data_o       = data_q;
  assign iter_cnt_o   = iter_q;
  assign busy_o       = busy_q;

endmodule
